extract_ctrl: RTL and testbench
===============================

# extract_ctrl

Frame-level sequencer for the radix-4 Viterbi decoder front end. Accepts one traceback-depth data frame over a valid/ready handshake, registers it toward the symbol slicer, and asserts the slicer's extract enable for exactly one frame's worth of symbols. It then drives the ACS and traceback stages in order and reports frame completion, with a watchdog on traceback. It sits between the input framer and the slice → ACS → traceback datapath.

## Interface
- TB_DEPTH, default `TRACEBACK_DEPTH (120; 60 also legal), frame width in bits
- RADIX, default `RADIX (4), bits consumed per extract cycle
- TB_TIMEOUT, default 256, max cycles allowed in TRACEBACK before error
- clk  in  1  rising-edge clock; one clock domain only
- rst  in  1  asynchronous, active-low reset
- i_flush  in  1  synchronous abort, highest priority after reset
- i_frame_valid  in  1  upstream frame present
- i_frame  in  TB_DEPTH  frame data, MSB first
- o_frame_ready  out  1  controller can accept a frame
- o_data_frame  out  TB_DEPTH  registered frame driven to slicer
- o_en_extract  out  1  slicer extract enable
- o_sym_idx  out  SYM_W  index of symbol being extracted, 0..N_SYM-1
- o_en_acs  out  1  ACS enable, aligned to slicer's registered output
- o_en_traceback  out  1  traceback run request, level
- i_traceback_done  in  1  traceback finished, single-cycle pulse
- o_frame_done  out  1  one-cycle completion pulse
- o_error  out  1  one-cycle watchdog timeout pulse
- o_busy  out  1  high in any state other than IDLE

## Operation
- N_SYM = TB_DEPTH/RADIX (30 for defaults); SYM_W = clog2(N_SYM). TB_DEPTH not divisible by RADIX is a compile-time error.
- States: IDLE, EXTRACT, DRAIN, TRACEBACK, DONE.
- IDLE: o_frame_ready=1. On i_frame_valid&&o_frame_ready: o_data_frame<=i_frame; symbol counter<=0; go to EXTRACT.
- EXTRACT: o_en_extract=1, o_sym_idx=counter. Counter increments each cycle. At counter==N_SYM-1, go to DRAIN. No wrap past N_SYM-1.
- DRAIN: one cycle, so the last registered slicer symbol reaches ACS. Then go to TRACEBACK with the watchdog cleared.
- TRACEBACK: o_en_traceback=1; watchdog increments.
  - i_traceback_done: go to DONE.
  - Watchdog reaching TB_TIMEOUT-1 without done: pulse o_error, go to IDLE.
  - Done and timeout in the same cycle: done wins, no error.
- DONE: o_frame_done=1 for one cycle, then IDLE.
- o_en_acs = o_en_extract delayed one cycle (registered).
- i_traceback_done outside TRACEBACK is ignored.
- i_flush=1 in any state: next state IDLE, counters cleared, o_en_acs cleared. No o_frame_done or o_error pulse. o_data_frame holds its value. A frame offered during the flush cycle is not accepted.
- o_data_frame stays stable from acceptance until the next acceptance.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; o_data_frame=0; o_sym_idx=0.
  - All enables, o_frame_done, o_error, o_busy = 0.
  - o_frame_ready=0 while rst=0; 1 from the first cycle after release.
- Handshake at edge E0. o_en_extract is high for cycles 1..N_SYM after E0. o_en_acs is high for cycles 2..N_SYM+1. DRAIN is cycle N_SYM+1. TRACEBACK starts at cycle N_SYM+2.
- Minimum latency: with done on the first TRACEBACK cycle, o_frame_done is at cycle N_SYM+3 and o_frame_ready returns at cycle N_SYM+4.
- Upstream holds i_frame/i_frame_valid while ready=0; the controller never drops a presented frame except during flush.
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.

## Structure
- Shared package viterbi_ctrl_pkg: state enum, N_SYM, SYM_W, and the default TB_TIMEOUT. Widths derive from the param_def.sv macros.
- Single module. The FSM, symbol counter, watchdog counter and ACS delay flop are all inline; no sub-module is warranted.
- The parent instantiates slice beside this block, wiring o_data_frame→i_data_frame and o_en_extract→en_extract.

## Test plan
- Reset mid-EXTRACT: assert rst=0 at sym_idx=12 → all outputs 0 immediately; after release ready=1 next cycle, and a new frame runs the full 30 extracts.
- Nominal frame (defaults): i_frame=120'hA5…, done 3 cycles into TRACEBACK → o_en_extract for 30 cycles with sym_idx 0..29; o_en_acs shifted +1; o_frame_done one pulse; o_data_frame=120'hA5….
- Back-to-back frames with valid held high → second handshake occurs the cycle ready reasserts; no gap in frame ordering; each frame produces exactly one done pulse.
- Watchdog: i_traceback_done never asserted, TB_TIMEOUT=16 → o_error pulses once after 16 TRACEBACK cycles; no o_frame_done; ready=1 the next cycle.
- Done at watchdog limit: done on cycle TB_TIMEOUT-1 → o_frame_done=1, o_error=0. Spurious done in IDLE → ignored.
- Flush in DRAIN and in TRACEBACK → IDLE next cycle; enables 0; no pulses; o_data_frame unchanged.

Source files
------------

// File: rtl/viterbi_ctrl_pkg.sv
// Shared definitions for the Viterbi front-end frame controller: default
// frame geometry, watchdog limit and the controller state encoding.
`ifndef TRACEBACK_DEPTH
`define TRACEBACK_DEPTH 120
`endif
`ifndef RADIX
`define RADIX 4
`endif

package viterbi_ctrl_pkg;

  localparam int TB_DEPTH_DEF   = `TRACEBACK_DEPTH;
  localparam int RADIX_DEF      = `RADIX;
  localparam int TB_TIMEOUT_DEF = 256;

  localparam int N_SYM = TB_DEPTH_DEF / RADIX_DEF;
  localparam int SYM_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXTRACT   = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_TRACEBACK = 3'd3,
    ST_DONE      = 3'd4
  } ctrl_state_t;

  // Counter width helper; never returns zero so a 1-entry range still has a bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/extract_ctrl.sv
// Frame sequencer: accepts one traceback-depth frame, runs the slicer for
// N_SYM extract cycles, drains into ACS, then supervises traceback.
module extract_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int  TB_DEPTH   = TB_DEPTH_DEF,
  parameter int  RADIX      = RADIX_DEF,
  parameter int  TB_TIMEOUT = TB_TIMEOUT_DEF,
  localparam int P_N_SYM    = TB_DEPTH / RADIX,
  localparam int P_SYM_W    = clog2_min1(P_N_SYM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic                i_frame_valid,
  input  logic [TB_DEPTH-1:0] i_frame,
  output logic                o_frame_ready,
  output logic [TB_DEPTH-1:0] o_data_frame,
  output logic                o_en_extract,
  output logic [P_SYM_W-1:0]  o_sym_idx,
  output logic                o_en_acs,
  output logic                o_en_traceback,
  input  logic                i_traceback_done,
  output logic                o_frame_done,
  output logic                o_error,
  output logic                o_busy,
  output logic [2:0]          o_dbg_state
);

  localparam int                 P_WD_W     = clog2_min1(TB_TIMEOUT);
  localparam logic [P_SYM_W-1:0] P_SYM_LAST = P_SYM_W'(P_N_SYM - 1);
  localparam logic [P_WD_W-1:0]  P_WD_LAST  = P_WD_W'(TB_TIMEOUT - 1);

  if ((RADIX < 1) || (TB_DEPTH % RADIX != 0)) begin : g_bad_geometry
    $error("extract_ctrl: TB_DEPTH must be a multiple of RADIX");
  end

  ctrl_state_t         r_state;
  ctrl_state_t         w_state_nxt;
  logic [P_SYM_W-1:0]  r_sym_cnt;
  logic [P_SYM_W-1:0]  w_sym_nxt;
  logic [P_WD_W-1:0]   r_wd_cnt;
  logic [P_WD_W-1:0]   w_wd_nxt;
  logic [TB_DEPTH-1:0] r_data_frame;
  logic                r_en_acs;
  logic                r_error;
  logic                r_ready_en;
  logic                w_err_nxt;
  logic                w_load;
  logic                w_frame_ready;

  // Handshake: a frame transfers on a rising edge where i_frame_valid and
  // o_frame_ready are both high and i_flush is low. o_frame_ready is decoded
  // from registered state only; upstream must hold valid/data until transfer.
  assign w_frame_ready = (r_state == ST_IDLE) && r_ready_en;

  always_comb begin
    w_state_nxt = r_state;
    w_sym_nxt   = r_sym_cnt;
    w_wd_nxt    = r_wd_cnt;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
      w_sym_nxt   = '0;
      w_wd_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_frame_valid && w_frame_ready) begin
            w_load      = 1'b1;
            w_sym_nxt   = '0;
            w_state_nxt = ST_EXTRACT;
          end
        end
        ST_EXTRACT: begin
          if (r_sym_cnt == P_SYM_LAST) begin
            w_sym_nxt   = '0;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_sym_nxt = r_sym_cnt + P_SYM_W'(1);
          end
        end
        ST_DRAIN: begin
          w_wd_nxt    = '0;
          w_state_nxt = ST_TRACEBACK;
        end
        ST_TRACEBACK: begin
          // A done arriving on the final watchdog cycle still counts as success.
          if (i_traceback_done) begin
            w_wd_nxt    = '0;
            w_state_nxt = ST_DONE;
          end else if (r_wd_cnt == P_WD_LAST) begin
            w_wd_nxt    = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_wd_nxt = r_wd_cnt + P_WD_W'(1);
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_sym_cnt    <= '0;
      r_wd_cnt     <= '0;
      r_data_frame <= '0;
      r_en_acs     <= 1'b0;
      r_error      <= 1'b0;
      r_ready_en   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sym_cnt  <= w_sym_nxt;
      r_wd_cnt   <= w_wd_nxt;
      r_error    <= w_err_nxt;
      r_ready_en <= 1'b1;
      // ACS sees the slicer's registered symbol one cycle after extract.
      r_en_acs   <= !i_flush && (r_state == ST_EXTRACT);
      if (w_load) begin
        r_data_frame <= i_frame;
      end
    end
  end

  assign o_frame_ready  = w_frame_ready;
  assign o_data_frame   = r_data_frame;
  assign o_en_extract   = (r_state == ST_EXTRACT);
  assign o_sym_idx      = r_sym_cnt;
  assign o_en_acs       = r_en_acs;
  assign o_en_traceback = (r_state == ST_TRACEBACK);
  assign o_frame_done   = (r_state == ST_DONE);
  assign o_error        = r_error;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_extract_ctrl.sv
// Directed bench for extract_ctrl: reset, nominal frame, back-to-back,
// watchdog timeout, done at the limit, spurious done and flush.
module tb_extract_ctrl;

  localparam int TBD = 120;
  localparam int RDX = 4;
  localparam int TO  = 16;
  localparam int N   = TBD / RDX;
  localparam int SW  = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           i_flush = 1'b0;
  logic           i_frame_valid = 1'b0;
  logic [TBD-1:0] i_frame = '0;
  logic           i_traceback_done = 1'b0;
  logic           o_frame_ready;
  logic [TBD-1:0] o_data_frame;
  logic           o_en_extract;
  logic [SW-1:0]  o_sym_idx;
  logic           o_en_acs;
  logic           o_en_traceback;
  logic           o_frame_done;
  logic           o_error;
  logic           o_busy;
  logic [2:0]     o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic          obs_ext[0:63];
  logic          obs_acs[0:63];
  logic [SW-1:0] obs_idx[0:63];

  localparam logic [TBD-1:0] FRAME_A5 = 120'hA5C3_0F1E_2D3C_4B5A_6978_8796_A5B4_C3;
  localparam logic [TBD-1:0] FRAME_B  = 120'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_43;
  localparam logic [TBD-1:0] FRAME_C  = 120'hFFEE_DDCC_BBAA_9988_7766_5544_3322_11;

  extract_ctrl #(.TB_DEPTH(TBD), .RADIX(RDX), .TB_TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_flush          (i_flush),
    .i_frame_valid    (i_frame_valid),
    .i_frame          (i_frame),
    .o_frame_ready    (o_frame_ready),
    .o_data_frame     (o_data_frame),
    .o_en_extract     (o_en_extract),
    .o_sym_idx        (o_sym_idx),
    .o_en_acs         (o_en_acs),
    .o_en_traceback   (o_en_traceback),
    .i_traceback_done (i_traceback_done),
    .o_frame_done     (o_frame_done),
    .o_error          (o_error),
    .o_busy           (o_busy),
    .o_dbg_state      (o_dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (o_frame_done) done_cnt++;
      if (o_error) err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_frame(input logic [TBD-1:0] f);
    int guard;
    guard = 0;
    while (o_frame_ready !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 100) begin
      n_errors++;
      $display("FAIL ready_wait: o_frame_ready=%b after %0d cycles, required 1", o_frame_ready, guard);
    end
    i_frame       = f;
    i_frame_valid = 1'b1;
    step();
    i_frame_valid = 1'b0;
  endtask

  // Records outputs for cycles 1..n after the handshake edge.
  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      obs_ext[k] = o_en_extract;
      obs_acs[k] = o_en_acs;
      obs_idx[k] = o_sym_idx;
      step();
    end
  endtask

  task automatic pulse_done_after(input int d);
    repeat (d - 1) step();
    i_traceback_done = 1'b1;
    step();
    i_traceback_done = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    step();
    step();
    n_checks++;
    if ({o_frame_ready, o_busy, o_en_extract, o_en_acs, o_en_traceback, o_frame_done, o_error} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {o_frame_ready, o_busy, o_en_extract, o_en_acs, o_en_traceback, o_frame_done, o_error});
    end
    n_checks++;
    if (o_data_frame !== '0 || o_sym_idx !== '0 || o_dbg_state !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_regs: data=%h idx=%0d state=%0d required 0/0/0", o_data_frame, o_sym_idx, o_dbg_state);
    end
    rst = 1'b1;
    n_checks++;
    if (o_frame_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_at_release: got %b required 0", o_frame_ready);
    end
    step();
    n_checks++;
    if (o_frame_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_release: got %b required 1", o_frame_ready);
    end
  endtask

  task automatic test_nominal();
    int bad_ext, bad_acs, bad_idx, d0, e0;
    bad_ext = 0; bad_acs = 0; bad_idx = 0;
    d0 = done_cnt; e0 = err_cnt;
    offer_frame(FRAME_A5);
    capture(N + 1);
    for (int k = 1; k <= N + 1; k++) begin
      if (obs_ext[k] !== (k <= N)) bad_ext++;
      if (obs_acs[k] !== (k >= 2)) bad_acs++;
      if (k <= N && obs_idx[k] !== SW'(k - 1)) bad_idx++;
    end
    n_checks++;
    if (bad_ext != 0) begin
      n_errors++;
      $display("FAIL nom_extract_window: %0d wrong cycles, required 0", bad_ext);
    end
    n_checks++;
    if (bad_acs != 0) begin
      n_errors++;
      $display("FAIL nom_acs_window: %0d wrong cycles, required 0", bad_acs);
    end
    n_checks++;
    if (bad_idx != 0) begin
      n_errors++;
      $display("FAIL nom_sym_idx: %0d wrong indices, required 0", bad_idx);
    end
    n_checks++;
    if (o_en_traceback !== 1'b1 || o_en_acs !== 1'b0 || o_dbg_state !== 3'd3) begin
      n_errors++;
      $display("FAIL nom_tb_entry: tb=%b acs=%b state=%0d required 1/0/3", o_en_traceback, o_en_acs, o_dbg_state);
    end
    pulse_done_after(3);
    n_checks++;
    if (o_frame_done !== 1'b1 || o_en_traceback !== 1'b0) begin
      n_errors++;
      $display("FAIL nom_done: done=%b tb=%b required 1/0", o_frame_done, o_en_traceback);
    end
    step();
    n_checks++;
    if (o_frame_done !== 1'b0 || o_frame_ready !== 1'b1 || o_data_frame !== FRAME_A5) begin
      n_errors++;
      $display("FAIL nom_return_idle: done=%b ready=%b data=%h required 0/1/%h",
               o_frame_done, o_frame_ready, o_data_frame, FRAME_A5);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      n_errors++;
      $display("FAIL nom_pulse_count: done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int bad_ext, d0;
    bad_ext = 0;
    d0 = done_cnt;
    offer_frame(FRAME_B);
    i_frame       = FRAME_C;
    i_frame_valid = 1'b1;
    capture(N + 1);
    pulse_done_after(1);
    n_checks++;
    if (o_frame_done !== 1'b1 || o_frame_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_min_latency_done: done=%b ready=%b required 1/0", o_frame_done, o_frame_ready);
    end
    step();
    n_checks++;
    if (o_frame_ready !== 1'b1 || o_data_frame !== FRAME_B) begin
      n_errors++;
      $display("FAIL b2b_ready_return: ready=%b data=%h required 1/%h", o_frame_ready, o_data_frame, FRAME_B);
    end
    step();
    i_frame_valid = 1'b0;
    n_checks++;
    if (o_data_frame !== FRAME_C || o_en_extract !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_second_accept: data=%h ext=%b required %h/1", o_data_frame, o_en_extract, FRAME_C);
    end
    capture(N + 1);
    for (int k = 1; k <= N + 1; k++) begin
      if (obs_ext[k] !== (k <= N)) bad_ext++;
      if (k <= N && obs_idx[k] !== SW'(k - 1)) bad_ext++;
    end
    n_checks++;
    if (bad_ext != 0) begin
      n_errors++;
      $display("FAIL b2b_second_extract: %0d wrong cycles, required 0", bad_ext);
    end
    pulse_done_after(2);
    step();
    n_checks++;
    if (done_cnt - d0 != 2) begin
      n_errors++;
      $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0);
    end
  endtask

  task automatic test_watchdog();
    int tb_cycles, d0, e0;
    tb_cycles = 0;
    d0 = done_cnt; e0 = err_cnt;
    offer_frame(FRAME_A5);
    capture(N + 1);
    while (o_en_traceback === 1'b1 && tb_cycles < 40) begin
      tb_cycles++;
      step();
    end
    n_checks++;
    if (tb_cycles != TO) begin
      n_errors++;
      $display("FAIL wd_tb_cycles: got %0d required %0d", tb_cycles, TO);
    end
    n_checks++;
    if (o_error !== 1'b1 || o_frame_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL wd_error_pulse: err=%b ready=%b busy=%b required 1/1/0", o_error, o_frame_ready, o_busy);
    end
    step();
    n_checks++;
    if (o_error !== 1'b0 || err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      n_errors++;
      $display("FAIL wd_single_pulse: err=%b errs=%0d dones=%0d required 0/1/0",
               o_error, err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_done_at_limit();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    offer_frame(FRAME_B);
    capture(N + 1);
    pulse_done_after(TO);
    n_checks++;
    if (o_frame_done !== 1'b1 || o_error !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_done_wins: done=%b err=%b required 1/0", o_frame_done, o_error);
    end
    step();
    step();
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      n_errors++;
      $display("FAIL limit_pulse_count: done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    end
    d0 = done_cnt;
    i_traceback_done = 1'b1;
    step();
    step();
    step();
    i_traceback_done = 1'b0;
    step();
    n_checks++;
    if (o_busy !== 1'b0 || o_dbg_state !== 3'd0 || done_cnt != d0 || o_en_traceback !== 1'b0) begin
      n_errors++;
      $display("FAIL spurious_done: busy=%b state=%0d dones=%0d tb=%b required 0/0/0/0",
               o_busy, o_dbg_state, done_cnt - d0, o_en_traceback);
    end
  endtask

  task automatic test_flush();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    offer_frame(FRAME_C);
    capture(N);
    n_checks++;
    if (o_dbg_state !== 3'd2 || o_en_acs !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_drain_setup: state=%0d acs=%b required 2/1", o_dbg_state, o_en_acs);
    end
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    n_checks++;
    if ({o_busy, o_en_extract, o_en_acs, o_en_traceback, o_frame_done, o_error} !== 6'b0 ||
        o_frame_ready !== 1'b1 || o_data_frame !== FRAME_C) begin
      n_errors++;
      $display("FAIL flush_drain: flags=%b ready=%b data=%h required 000000/1/%h",
               {o_busy, o_en_extract, o_en_acs, o_en_traceback, o_frame_done, o_error},
               o_frame_ready, o_data_frame, FRAME_C);
    end
    i_frame       = FRAME_A5;
    i_frame_valid = 1'b1;
    i_flush       = 1'b1;
    step();
    i_flush       = 1'b0;
    i_frame_valid = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_data_frame !== FRAME_C) begin
      n_errors++;
      $display("FAIL flush_blocks_accept: busy=%b data=%h required 0/%h", o_busy, o_data_frame, FRAME_C);
    end
    offer_frame(FRAME_B);
    capture(N + 1);
    step();
    step();
    n_checks++;
    if (o_en_traceback !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_tb_setup: tb=%b required 1", o_en_traceback);
    end
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    n_checks++;
    if ({o_busy, o_en_extract, o_en_acs, o_en_traceback, o_frame_done, o_error} !== 6'b0 ||
        o_data_frame !== FRAME_B) begin
      n_errors++;
      $display("FAIL flush_tb: flags=%b data=%h required 000000/%h",
               {o_busy, o_en_extract, o_en_acs, o_en_traceback, o_frame_done, o_error}, o_data_frame, FRAME_B);
    end
    repeat (TO + 4) step();
    n_checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      n_errors++;
      $display("FAIL flush_no_pulses: dones=%0d errs=%0d required 0/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_extract();
    int cnt;
    cnt = 0;
    offer_frame(FRAME_A5);
    capture(12);
    n_checks++;
    if (o_sym_idx !== SW'(12) || o_en_extract !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_setup: idx=%0d ext=%b required 12/1", o_sym_idx, o_en_extract);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({o_frame_ready, o_busy, o_en_extract, o_en_acs, o_en_traceback, o_frame_done, o_error} !== 7'b0 ||
        o_sym_idx !== '0 || o_data_frame !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_async: flags=%b idx=%0d data=%h required 0000000/0/0",
               {o_frame_ready, o_busy, o_en_extract, o_en_acs, o_en_traceback, o_frame_done, o_error},
               o_sym_idx, o_data_frame);
    end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (o_frame_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_ready: got %b required 1", o_frame_ready);
    end
    offer_frame(FRAME_C);
    capture(N + 1);
    for (int k = 1; k <= N + 1; k++) begin
      if (obs_ext[k] === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != N) begin
      n_errors++;
      $display("FAIL rst_mid_full_frame: extracts=%0d required %0d", cnt, N);
    end
    pulse_done_after(1);
    step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_watchdog();
    test_done_at_limit();
    test_flush();
    test_reset_mid_extract();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
